// File: rtl/sign_extender_if.sv
// Bus bundle for sign_extender: input field, valid qualifier, combinational and registered results.
// Optional zext mode select is present only when SIGN_EXTENDER_ZEXT_EN is defined.
interface sign_extender_if #(
  parameter int unsigned NUM_IN_BITS  = 11,
  parameter int unsigned NUM_OUT_BITS = 64
);
  logic [NUM_IN_BITS-1:0]  in;
  logic                    in_valid;
`ifdef SIGN_EXTENDER_ZEXT_EN
  logic                    zext;
`endif
  logic [NUM_OUT_BITS-1:0] out;
  logic [NUM_OUT_BITS-1:0] out_q;
  logic                    out_valid;

  modport master (
    output in,
    output in_valid,
`ifdef SIGN_EXTENDER_ZEXT_EN
    output zext,
`endif
    input  out,
    input  out_q,
    input  out_valid
  );

  modport slave (
    input  in,
    input  in_valid,
`ifdef SIGN_EXTENDER_ZEXT_EN
    input  zext,
`endif
    output out,
    output out_q,
    output out_valid
  );
endinterface

// File: rtl/sign_extender.sv
// Sign/zero extender with a combinational result and a 1-cycle registered copy.
// SIGN_EXTENDER_ZEXT_EN enables the zext mode input; otherwise the block always sign-extends.
module sign_extender #(
  parameter int unsigned NUM_IN_BITS  = 11,
  parameter int unsigned NUM_OUT_BITS = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  sign_extender_if.slave   bus
);

  localparam int unsigned EXT_BITS = (NUM_OUT_BITS > NUM_IN_BITS) ? (NUM_OUT_BITS - NUM_IN_BITS) : 1;

  // Parameter legality is enforced at elaboration.
  if (NUM_IN_BITS < 1) begin : g_chk_in
    $error("sign_extender: NUM_IN_BITS must be >= 1");
  end
  if (NUM_OUT_BITS < NUM_IN_BITS) begin : g_chk_out
    $error("sign_extender: NUM_OUT_BITS must be >= NUM_IN_BITS");
  end

  logic [NUM_OUT_BITS-1:0] w_out;
  logic [NUM_OUT_BITS-1:0] r_out_q;
  logic                    r_out_valid;

  // Upper bits exist only when the result is wider than the input field.
  if (NUM_OUT_BITS > NUM_IN_BITS) begin : g_ext
    logic w_fill;
`ifdef SIGN_EXTENDER_ZEXT_EN
    assign w_fill = bus.in[NUM_IN_BITS-1] & ~bus.zext;
`else
    assign w_fill = bus.in[NUM_IN_BITS-1];
`endif
    assign w_out = {{EXT_BITS{w_fill}}, bus.in};
  end else begin : g_noext
`ifdef SIGN_EXTENDER_ZEXT_EN
    logic w_unused_zext;
    assign w_unused_zext = bus.zext;
`endif
    assign w_out = NUM_OUT_BITS'(bus.in);
  end

  // Registered copy: load on valid, hold otherwise; valid tracks in_valid each edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_q     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_out_q <= w_out;
      end
    end
  end

  assign bus.out       = w_out;
  assign bus.out_q     = r_out_q;
  assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_sign_extender.sv
// Self-checking bench for sign_extender: scoreboard queue of expected registered results.
module tb_sign_extender;

  localparam int unsigned NI = 11;
  localparam int unsigned NO = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic z_mode = 1'b0;

  always #5 clk = ~clk;

  sign_extender_if #(.NUM_IN_BITS(NI), .NUM_OUT_BITS(NO)) bus ();

  sign_extender #(.NUM_IN_BITS(NI), .NUM_OUT_BITS(NO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef SIGN_EXTENDER_ZEXT_EN
  assign bus.zext = z_mode;
`endif

  int errors = 0;
  int checks = 0;
  logic [NO-1:0] exp_q[$];
  logic [NO-1:0] held = '0;

  // Bit-by-bit reference extension.
  function automatic logic [NO-1:0] model(input logic [NI-1:0] v, input logic z);
    logic [NO-1:0] r;
    r = '0;
    for (int i = 0; i < int'(NI); i++) r[i] = v[i];
    if (!z && v[NI-1]) begin
      for (int i = int'(NI); i < int'(NO); i++) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Apply inputs at the falling edge; queue the expected registered result when valid.
  task automatic drive(input logic v, input logic [NI-1:0] d, input logic z);
    @(negedge clk);
    bus.in      = d;
    bus.in_valid = v;
    z_mode      = z;
    if (v) exp_q.push_back(model(d, z));
  endtask

  task automatic test_reset();
    logic [NO-1:0] want;
    bus.in = 11'h7FF; bus.in_valid = 1'b1; z_mode = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.out_q !== '0) begin errors++; $display("FAIL reset_out_q got=%h want=0", bus.out_q); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    want = 64'hFFFF_FFFF_FFFF_FFFF;
    checks++;
    if (bus.out !== want) begin errors++; $display("FAIL reset_comb got=%h want=%h", bus.out, want); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    held = '0;
    exp_q.delete();
  endtask

  task automatic test_vectors();
    logic [NI-1:0] vin [6];
    logic [NO-1:0] vout [6];
    logic [NO-1:0] want;
    vin[0] = 11'h000; vout[0] = 64'h0000_0000_0000_0000;
    vin[1] = 11'h0FF; vout[1] = 64'h0000_0000_0000_00FF;
    vin[2] = 11'h7FF; vout[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    vin[3] = 11'h400; vout[3] = 64'hFFFF_FFFF_FFFF_FC00;
    vin[4] = 11'h3FF; vout[4] = 64'h0000_0000_0000_03FF;
    vin[5] = 11'h001; vout[5] = 64'h0000_0000_0000_0001;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, vin[k], 1'b0);
      #1;
      checks++;
      if (bus.out !== vout[k]) begin errors++; $display("FAIL vec_comb[%0d] in=%h got=%h want=%h", k, vin[k], bus.out, vout[k]); end
      @(posedge clk); #1;
      want = exp_q.pop_front();
      held = want;
      checks++;
      if (bus.out_q !== want) begin errors++; $display("FAIL vec_out_q[%0d] got=%h want=%h", k, bus.out_q, want); end
      checks++;
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL vec_valid[%0d] got=%b want=1", k, bus.out_valid); end
    end
  endtask

  task automatic test_hold();
    logic [NO-1:0] want;
    drive(1'b1, 11'h7FF, 1'b0);
    @(posedge clk); #1;
    held = exp_q.pop_front();
    checks++;
    if (bus.out_q !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL hold_load got=%h want=all ones", bus.out_q); end
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL hold_load_valid got=%b want=1", bus.out_valid); end
    drive(1'b0, 11'h123, 1'b0);
    #1;
    want = 64'h0000_0000_0000_0123;
    checks++;
    if (bus.out !== want) begin errors++; $display("FAIL hold_comb got=%h want=%h", bus.out, want); end
    @(posedge clk); #1;
    checks++;
    if (bus.out_q !== held) begin errors++; $display("FAIL hold_out_q got=%h want=%h", bus.out_q, held); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL hold_valid got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [NI-1:0] d;
    logic v;
    logic [NO-1:0] want;
    for (int k = 0; k < 40; k++) begin
      d = NI'($urandom);
      v = (k < 20) ? 1'b1 : 1'($urandom_range(0, 1));
      drive(v, d, 1'b0);
      #1;
      checks++;
      if (bus.out !== model(d, 1'b0)) begin errors++; $display("FAIL b2b_comb[%0d] got=%h want=%h", k, bus.out, model(d, 1'b0)); end
      @(posedge clk); #1;
      if (v) begin
        want = exp_q.pop_front();
        held = want;
      end
      checks++;
      if (bus.out_q !== held) begin errors++; $display("FAIL b2b_out_q[%0d] got=%h want=%h", k, bus.out_q, held); end
      checks++;
      if (bus.out_valid !== v) begin errors++; $display("FAIL b2b_valid[%0d] got=%b want=%b", k, bus.out_valid, v); end
    end
  endtask

  task automatic test_mid_reset();
    logic [NO-1:0] want;
    drive(1'b1, 11'h7FF, 1'b0);
    @(posedge clk); #1;
    held = exp_q.pop_front();
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mrst_pre_valid got=%b want=1", bus.out_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_q !== '0) begin errors++; $display("FAIL mrst_out_q got=%h want=0", bus.out_q); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid got=%b want=0", bus.out_valid); end
    held = '0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 11'h001, 1'b0);
    @(posedge clk); #1;
    want = exp_q.pop_front();
    held = want;
    checks++;
    if (bus.out_q !== 64'h1) begin errors++; $display("FAIL mrst_first got=%h want=1", bus.out_q); end
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mrst_first_valid got=%b want=1", bus.out_valid); end
  endtask

`ifdef SIGN_EXTENDER_ZEXT_EN
  task automatic test_zext();
    logic [NI-1:0] vin [3];
    logic [NO-1:0] want;
    vin[0] = 11'h7FF; vin[1] = 11'h400; vin[2] = 11'h0FF;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, vin[k], 1'b1);
      #1;
      want = NO'(vin[k]);
      checks++;
      if (bus.out !== want) begin errors++; $display("FAIL zext_comb[%0d] got=%h want=%h", k, bus.out, want); end
      @(posedge clk); #1;
      want = exp_q.pop_front();
      held = want;
      checks++;
      if (bus.out_q !== want) begin errors++; $display("FAIL zext_out_q[%0d] got=%h want=%h", k, bus.out_q, want); end
    end
    drive(1'b0, 11'h7FF, 1'b0);
    #1;
    checks++;
    if (bus.out !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL zext_back_sign got=%h", bus.out); end
  endtask
`endif

  initial begin
    bus.in = '0;
    bus.in_valid = 1'b0;
    test_reset();
    test_vectors();
    test_hold();
    test_back_to_back();
    test_mid_reset();
`ifdef SIGN_EXTENDER_ZEXT_EN
    test_zext();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
